display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
//   Time-multiplexes the six 7-segment patterns of the clock (ss, mm, hh) onto one
//   shared segment bus with per-digit active-low anode enables. Sits directly
//   downstream of the clock top level and consumes its six display outputs.
//   Adds inter-frame snapshotting (no tearing), anti-ghosting guard time and a
//   1 Hz blinking separator dot.
// PARAMETERS
//   DWELL_CYCLES  50000  main_clock cycles per digit slot (frame = 6*DWELL_CYCLES)
//   GUARD_CYCLES  500    cycles at start of each slot with all anodes/segments off
// PORTS
//   main_clock  in   1  system clock
//   main_reset  in   1  asynchronous reset, active-low
//   enable_1hz  in   1  one-cycle pulse at 1 Hz, synchronous to main_clock
//   blank_en    in   1  1 = force display dark; scan keeps running
//   s_lsd       in   7  seconds units pattern, active-low segments
//   s_msd       in   7  seconds tens pattern
//   m_lsd       in   7  minutes units pattern
//   m_msd       in   7  minutes tens pattern
//   h_lsd       in   7  hours units pattern
//   h_msd       in   7  hours tens pattern
//   seg_out     out  7  shared segment bus, active-low (7'h7F = all off)
//   dp_out      out  1  shared decimal point, active-low
//   an_out      out  6  digit enables, active-low, bit i = slot i
// BEHAVIOUR
//   - Reset (main_reset=0, async): cnt=0, idx=0, blink=0, snap[0..5]=7'h7F,
//     an_out=6'h3F, seg_out=7'h7F, dp_out=1.
//   - cnt counts 0..DWELL_CYCLES-1 each cycle, then wraps to 0 and idx advances.
//     idx runs 0..5, then wraps 5->0.
//   - Slot map: 0=s_lsd, 1=s_msd, 2=m_lsd, 3=m_msd, 4=h_lsd, 5=h_msd.
//   - Snapshot rule: on the edge where cnt==DWELL_CYCLES-1 and idx==5, all six
//     inputs are captured into snap[] together. The new frame's slot 0 already
//     shows the new values. Input changes mid-frame are not visible until the
//     next frame. The first frame after reset shows blank (7'h7F) patterns.
//   - Outputs are registered. The value driven after edge k reflects cnt/idx/
//     snap/blink/blank_en as they were before edge k (1-cycle latency).
//   - Guard: if cnt < GUARD_CYCLES or blank_en=1, then an_out=6'h3F,
//     seg_out=7'h7F, dp_out=1.
//   - Otherwise: an_out = ~(6'b1 << idx), seg_out = snap[idx],
//     dp_out = ~(blink & (idx==2 | idx==4)).
//     This gives hh.mm.ss separators on the units digits of h and m.
//   - blink toggles on every cycle with enable_1hz=1. It is independent of the
//     scan: a pulse on the frame-wrap edge both toggles blink and loads snap.
//   - At most one anode is low in any cycle. an_out is never 0 on two bits at once.
//   - Async reset mid-slot: outputs go dark immediately. The scan restarts at
//     slot 0 with the guard interval after release.
//   - Legal params: DWELL_CYCLES>=2, 0<=GUARD_CYCLES<DWELL_CYCLES.
//     Counter width = $clog2(DWELL_CYCLES).
// TESTING (DWELL_CYCLES=8, GUARD_CYCLES=2)
//   1. Release reset with inputs static (s_lsd=7'h40, h_msd=7'h79) ->
//      an_out=6'h3F for edges 1-2. an_out=6'b111110 with seg_out=7'h7F on edges 3-8.
//      In frame 2, slot 0 shows seg_out=7'h40 and slot 5 shows 7'h79.
//   2. Change m_lsd 7'h40->7'h24 during frame 2, slot 1 ->
//      slot 2 keeps 7'h40 in frame 2. It shows 7'h24 only from frame 3.
//   3. Pulse enable_1hz once -> dp_out=0 only during the non-guard cycles of slots 2 and 4.
//      A second pulse -> dp_out stays 1 in all slots.
//   4. Hold blank_en=1 for 20 cycles ->
//      an_out=6'h3F and seg_out=7'h7F, starting 1 cycle after assertion.
//      Deassert -> the scan resumes at the idx it has reached, with no restart.
//   5. Assert main_reset during slot 3 at cnt=5 ->
//      outputs dark asynchronously; snap back to 7'h7F; after release, slot 0 guard first.
//   6. Run 3 frames with random inputs ->
//      checker confirms at most one low bit in an_out, slot order 0..5, period 48 cycles.

Source files
------------

// File: rtl/display_scan.sv
// Six-digit 7-segment scanner: frame snapshot, guard time
// and blinking hh.mm.ss separators.
module display_scan #(
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic       main_clock,
  input  logic       main_reset,
  input  logic       enable_1hz,
  input  logic       blank_en,
  input  logic [6:0] s_lsd,
  input  logic [6:0] s_msd,
  input  logic [6:0] m_lsd,
  input  logic [6:0] m_msd,
  input  logic [6:0] h_lsd,
  input  logic [6:0] h_msd,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] an_out
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          blink;
  logic [6:0]    snap [6];
  logic [6:0]    cur_seg;
  logic          slot_end;
  logic          frame_end;
  logic          dark;
  logic          sep;

  always_comb begin
    cur_seg = 7'h7F;
    unique case (idx)
      3'd0:    cur_seg = snap[0];
      3'd1:    cur_seg = snap[1];
      3'd2:    cur_seg = snap[2];
      3'd3:    cur_seg = snap[3];
      3'd4:    cur_seg = snap[4];
      3'd5:    cur_seg = snap[5];
      default: cur_seg = 7'h7F;
    endcase
  end

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 3'd5);
  assign dark      = (cnt < GUARD) || blank_en;
  // Separator dots sit on the units digits of minutes and hours.
  assign sep       = blink && ((idx == 3'd2) || (idx == 3'd4));

  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      cnt   <= '0;
      idx   <= '0;
      blink <= 1'b0;
      for (int i = 0; i < 6; i++) snap[i] <= 7'h7F;
      an_out  <= 6'h3F;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // Whole-frame capture so a digit never tears mid-scan.
      if (frame_end) begin
        snap[0] <= s_lsd;
        snap[1] <= s_msd;
        snap[2] <= m_lsd;
        snap[3] <= m_msd;
        snap[4] <= h_lsd;
        snap[5] <= h_msd;
      end
      if (enable_1hz) blink <= ~blink;
      if (dark) begin
        an_out  <= 6'h3F;
        seg_out <= 7'h7F;
        dp_out  <= 1'b1;
      end else begin
        an_out  <= ~(6'd1 << idx);
        seg_out <= cur_seg;
        dp_out  <= ~sep;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: a time-indexed reference model feeds
// an expectation queue consumed by per-scenario tasks.
module tb_display_scan;

  logic       clk;
  logic       rst_n;
  logic       en1;
  logic       blank;
  logic [6:0] sl, sm, ml, mm, hl, hm;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   m_t;
  logic m_blink;
  logic [6:0] m_fd [6];

  display_scan #(.DWELL_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .main_clock(clk),
    .main_reset(rst_n),
    .enable_1hz(en1),
    .blank_en(blank),
    .s_lsd(sl),
    .s_msd(sm),
    .m_lsd(ml),
    .m_msd(mm),
    .h_lsd(hl),
    .h_msd(hm),
    .seg_out(seg),
    .dp_out(dp),
    .an_out(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position in time since release gives slot and offset.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int off;
    int sl_i;
    if (!rst_n) begin
      m_t     <= 0;
      m_blink <= 1'b0;
      for (int i = 0; i < 6; i++) m_fd[i] <= 7'h7F;
    end else begin
      off  = m_t % 8;
      sl_i = (m_t / 8) % 6;
      if (off < 2 || blank) begin
        e = '{6'h3F, 7'h7F, 1'b1};
      end else begin
        e.an  = ~(6'd1 << sl_i);
        e.seg = m_fd[sl_i];
        e.dp  = ~(m_blink && (sl_i == 2 || sl_i == 4));
      end
      exp_q.push_back(e);
      if (m_t % 48 == 47) begin
        m_fd[0] <= sl; m_fd[1] <= sm;
        m_fd[2] <= ml; m_fd[3] <= mm;
        m_fd[4] <= hl; m_fd[5] <= hm;
      end
      if (en1) m_blink <= ~m_blink;
      m_t <= m_t + 1;
    end
  end

  task automatic test_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_out: got an=%h seg=%h dp=%b want 3f/7f/1",
               an, seg, dp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    exp_q.delete();
    for (int k = 1; k <= 96; k++) begin
      @(negedge clk);
      n_tests++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL basic_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (k <= 2) begin
        n_tests++;
        if (an !== 6'h3F) begin
          n_fail++;
          $display("FAIL basic_guard k=%0d: got an=%h want 3f", k, an);
        end
      end else if (k <= 8) begin
        n_tests++;
        if (an !== 6'h3E || seg !== 7'h7F) begin
          n_fail++;
          $display("FAIL basic_blank1 k=%0d: got %h/%h want 3e/7f",
                   k, an, seg);
        end
      end else if (k == 51) begin
        n_tests++;
        if (an !== 6'h3E || seg !== 7'h40) begin
          n_fail++;
          $display("FAIL basic_slot0 got %h/%h want 3e/40", an, seg);
        end
      end else if (k == 91) begin
        n_tests++;
        if (an !== 6'h1F || seg !== 7'h79) begin
          n_fail++;
          $display("FAIL basic_slot5 got %h/%h want 1f/79", an, seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    int f0;
    int tt;
    int guard;
    exp_q.delete();
    guard = 0;
    while (m_t % 48 != 11 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (m_t % 48 != 11) begin
      n_fail++;
      $display("FAIL snap_sync: timeout got t=%0d want slot1", m_t);
    end
    exp_q.delete();
    f0 = m_t / 48;
    ml = 7'h24;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      tt = m_t - 1;
      n_tests++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL snap_model t=%0d: got %h/%h/%b want %h/%h/%b",
                 tt, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (tt % 8 >= 2 && (tt / 8) % 6 == 2) begin
        if (tt / 48 == f0) begin
          n_tests++;
          if (seg !== 7'h40) begin
            n_fail++;
            $display("FAIL snap_old t=%0d: got %h want 40", tt, seg);
          end
        end else if (tt / 48 == f0 + 1) begin
          n_tests++;
          if (seg !== 7'h24) begin
            n_fail++;
            $display("FAIL snap_new t=%0d: got %h want 24", tt, seg);
          end
        end
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int lows;
    for (int p = 0; p < 2; p++) begin
      exp_q.delete();
      en1 = 1'b1;
      @(negedge clk);
      en1 = 1'b0;
      void'(exp_q.pop_front());
      lows = 0;
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        n_tests++;
        e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
        if ({an, seg, dp} !== e) begin
          n_fail++;
          $display("FAIL blink_model p=%0d: got %h/%h/%b want %h/%h/%b",
                   p, an, seg, dp, e.an, e.seg, e.dp);
        end
        if (dp === 1'b0) begin
          lows++;
          n_tests++;
          if (an !== 6'h3B && an !== 6'h2F) begin
            n_fail++;
            $display("FAIL blink_slot: dp low with an=%h want 3b or 2f", an);
          end
        end
      end
      n_tests++;
      if (lows != (p == 0 ? 12 : 0)) begin
        n_fail++;
        $display("FAIL blink_count p=%0d: got %0d want %0d",
                 p, lows, p == 0 ? 12 : 0);
      end
    end
  endtask

  task automatic test_blank();
    exp_t e;
    exp_q.delete();
    blank = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      n_tests++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL blank_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (k <= 20) begin
        n_tests++;
        if (an !== 6'h3F || seg !== 7'h7F) begin
          n_fail++;
          $display("FAIL blank_dark k=%0d: got %h/%h want 3f/7f",
                   k, an, seg);
        end
      end
      if (k == 20) blank = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int guard;
    guard = 0;
    while (m_t % 48 != 29 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (m_t % 48 != 29) begin
      n_fail++;
      $display("FAIL arst_sync: timeout got t=%0d", m_t);
    end
    n_tests++;
    if (an !== 6'h37) begin
      n_fail++;
      $display("FAIL arst_pre: got an=%h want 37", an);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL arst_dark: got %h/%h/%b want 3f/7f/1", an, seg, dp);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_tests++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL arst_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, an, seg, dp, e.an, e.seg, e.dp);
      end
      if (k <= 2 && an !== 6'h3F) begin
        n_fail++;
        $display("FAIL arst_guard k=%0d: got an=%h want 3f", k, an);
      end
      if (k >= 3 && k <= 8 && (an !== 6'h3E || seg !== 7'h7F)) begin
        n_fail++;
        $display("FAIL arst_snap k=%0d: got %h/%h want 3e/7f", k, an, seg);
      end
      if (k <= 8) n_tests++;
    end
  endtask

  task automatic test_random();
    exp_t e;
    int prev;
    int cur;
    int last0;
    int seen0;
    prev  = -1;
    last0 = -1;
    seen0 = 0;
    exp_q.delete();
    for (int k = 0; k < 144; k++) begin
      {sl, sm, ml} = 21'($urandom);
      {mm, hl, hm} = 21'($urandom);
      @(negedge clk);
      n_tests++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '{6'h00, 7'h00, 1'b0};
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL rand_model k=%0d: got %h/%h/%b want %h/%h/%b",
                 k, an, seg, dp, e.an, e.seg, e.dp);
      end
      n_tests++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL rand_onehot k=%0d: got an=%h want <=1 low", k, an);
      end
      cur = -1;
      for (int i = 0; i < 6; i++) if (an[i] === 1'b0) cur = i;
      if (cur >= 0 && cur != prev) begin
        if (prev >= 0) begin
          n_tests++;
          if (cur != (prev + 1) % 6) begin
            n_fail++;
            $display("FAIL rand_order: got slot %0d want %0d",
                     cur, (prev + 1) % 6);
          end
        end
        if (cur == 0) begin
          if (seen0 > 0) begin
            n_tests++;
            if (k - last0 != 48) begin
              n_fail++;
              $display("FAIL rand_period: got %0d want 48", k - last0);
            end
          end
          last0 = k;
          seen0++;
        end
        prev = cur;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    en1   = 1'b0;
    blank = 1'b0;
    sl = 7'h40; sm = 7'h79; ml = 7'h40;
    mm = 7'h30; hl = 7'h19; hm = 7'h79;
    test_reset();
    test_basic();
    test_snapshot();
    test_blink();
    test_blank();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
